key_event_ctrl: RTL and testbench
=================================

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 2: number of key inputs, legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk cycles required to accept a level change, minimum 2.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_port  input  NUM_KEYS  raw asynchronous key levels; 0 = pressed, 1 = released.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 write  input  1  Avalon-MM write strobe, single cycle.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data, registered.
REQ-010 irq  output  1  level interrupt, active-high.

Function
REQ-011 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per key: mismatch between synced level and debounced level increments a counter; match clears it; on the DEBOUNCE_CYCLES-th consecutive mismatch cycle the debounced level takes the synced value and the counter clears.
REQ-013 Input held stable after a change SHALL update the debounced level exactly 2 + DEBOUNCE_CYCLES clk edges later; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL be ignored.
REQ-014 Press event = debounced transition 1->0; release transitions SHALL generate no event.
REQ-015 Register map: addr 0 debounced levels (RO); addr 1 irq mask (RW, NUM_KEYS bits); addr 2 edge capture (R, write-1-to-clear per bit); addr 3 press counter (RO 16-bit, any write clears).
REQ-016 readdata SHALL be loaded every clk edge with the register selected by address, unused upper bits 0; read latency exactly 1 cycle; no read strobe.
REQ-017 Writes to addr 0 SHALL be ignored; writes to addr 1 SHALL take effect the next cycle.
REQ-018 Press event sets its edge-capture bit; a same-cycle write-1-clear of that bit SHALL leave the bit set (event wins).
REQ-019 Press counter SHALL add the number of press events in each cycle, saturating at 0xFFFF; a same-cycle clear SHALL load the count of that cycle's events.
REQ-020 irq = OR over (edge capture AND mask), driven from registers only, with no combinational path from in_port or bus inputs.
REQ-021 Keys SHALL be processed independently; simultaneous presses on several keys SHALL each be captured and counted.

Reset
REQ-022 Reset SHALL force: synchronizers and debounced levels to all-1 (released), counters to 0, mask to 0, edge capture to 0, press counter to 0, readdata to 0, irq to 0.
REQ-023 A key held pressed through reset deassertion SHALL produce exactly one press event, 2 + DEBOUNCE_CYCLES edges after reset release.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count; no event SHALL be generated from pre-reset activity.

Structure
REQ-025 Package key_event_pkg SHALL hold register address constants (ADDR_LEVEL=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_COUNT=3) and the press-counter width (16).
REQ-026 Sub-module key_debounce SHALL implement one key's synchronizer, counter and debounced level, plus a single-cycle press pulse; key_event_ctrl instantiates NUM_KEYS copies.
REQ-027 Counter width in key_debounce SHALL be derived from DEBOUNCE_CYCLES via $clog2.

Verification (bench uses DEBOUNCE_CYCLES=4, NUM_KEYS=2)
REQ-028 Key0 driven 1->0 and held -> addr0 reads 0x2 and addr2 reads 0x1 starting 6 edges after the change; addr3 reads 0x0001.
REQ-029 Key1 pulsed low for 3 cycles -> addr0 stays 0x3, addr2 stays 0x0, irq stays 0.
REQ-030 Mask written 0x1, key0 pressed -> irq=1; write 0x1 to addr2 -> irq=0 next cycle; bit re-set on next press.
REQ-031 Write-1-clear of addr2 bit1 in the same cycle as a key1 press event -> addr2 bit1 remains 1, addr3 increments by 1.
REQ-032 Both keys pressed in the same cycle -> addr2 = 0x3, addr3 increments by 2; counter preloaded to 0xFFFF stays at 0xFFFF.
REQ-033 reset_n pulsed low during a 2-cycle-old mismatch -> all registers 0 except addr0 = 0x3; no event until the key is stable for 6 edges after release.

Source files
------------

// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_pkg
//  Description : Shared constants for the key event controller: register
//                word addresses, press-counter width and a popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    localparam int CNT_W = 16;

    // Number of set bits in an up-to-8-key event vector
    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One key: 2-flop synchronizer, consecutive-mismatch counter,
//                debounced level and a single-cycle press (1->0) pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_synced;
    logic          w_mismatch;
    logic          w_accept;

    assign w_synced   = sync_q[1];
    assign w_mismatch = w_synced ^ level_q;
    // The counter only ever reaches N-1; the N-th mismatching cycle accepts.
    assign w_accept   = w_mismatch && (cnt_q == c_LAST);

    // Synchronize the raw key level; released (1) out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_i};
        end
    end

    // Count consecutive mismatches and flip the level on the last one
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!w_mismatch) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d   = '0;
            level_d = w_synced;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    // Asserted in the cycle the debounced level is about to fall
    assign press_o = w_accept && level_q;

endmodule
`default_nettype wire

// File: rtl/key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_ctrl
//  Description : Debounced push-key controller with Avalon-MM registers:
//                levels, irq mask, W1C edge capture, saturating press count.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] in_port,
    input  logic [1:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq
);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_press;
    logic [7:0]          w_press_ext;
    logic [3:0]          w_press_n;
    logic [CNT_W:0]      w_sum;
    logic [NUM_KEYS-1:0] w_clr;
    logic                w_unused_wdata;

    logic [NUM_KEYS-1:0] mask_q, mask_d;
    logic [NUM_KEYS-1:0] edge_q, edge_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         readdata_q, readdata_d;

    assign w_unused_wdata = &{1'b0, writedata[31:NUM_KEYS]};

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .key_i   (in_port[k]),
            .level_o (w_level[k]),
            .press_o (w_press[k])
        );
    end

    // Next-state for mask, edge capture, press counter and read data
    always_comb begin
        w_press_ext                 = '0;
        w_press_ext[NUM_KEYS-1:0]   = w_press;
        w_press_n                   = count_ones(w_press_ext);
        w_sum                       = {1'b0, count_q} + {{(CNT_W-3){1'b0}}, w_press_n};

        mask_d = mask_q;
        if (write && (address == ADDR_MASK)) begin
            mask_d = writedata[NUM_KEYS-1:0];
        end

        // A press in the same cycle as its clear keeps the bit set
        w_clr  = (write && (address == ADDR_EDGE)) ? writedata[NUM_KEYS-1:0] : '0;
        edge_d = (edge_q & ~w_clr) | w_press;

        if (write && (address == ADDR_COUNT)) begin
            count_d = {{(CNT_W-4){1'b0}}, w_press_n};
        end else if (w_sum[CNT_W]) begin
            count_d = '1;
        end else begin
            count_d = w_sum[CNT_W-1:0];
        end

        case (address)
            ADDR_LEVEL: readdata_d = 32'(w_level);
            ADDR_MASK:  readdata_d = 32'(mask_q);
            ADDR_EDGE:  readdata_d = 32'(edge_q);
            default:    readdata_d = 32'(count_q);
        endcase
    end

    // Register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            count_q    <= '0;
            readdata_q <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Built from registered state only
    assign irq      = |(edge_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_key_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_ctrl
//  Description : Self-checking bench for key_event_ctrl (2 keys, 4-cycle
//                debounce): directed scenarios then random traffic, all
//                compared every cycle against a sample-history model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_ctrl;

    localparam int NK = 2;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] in_port;
    logic [1:0]    address;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int total = 0;
    int bad   = 0;

    // Model: raw samples per edge (index 0 = newest), register contents
    logic [NK-1:0] hist [DB+2];
    logic [NK-1:0] m_level, m_mask, m_edge;
    int            m_count;
    logic [31:0]   exp_rd;
    logic          exp_irq;

    key_event_ctrl #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [NK-1:0] v);
        int n = 0;
        for (int i = 0; i < NK; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DB + 2; i++) hist[i] = '1;
        m_level = '1;
        m_mask  = '0;
        m_edge  = '0;
        m_count = 0;
        exp_rd  = '0;
        exp_irq = 1'b0;
    endtask

    // A key's level flips once its last DB synchronized samples all disagree
    task automatic model_edge();
        logic [NK-1:0] new_level, press, clr;
        int            p;
        bit            all_diff;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (address)
            2'd0:    exp_rd = 32'(m_level);
            2'd1:    exp_rd = 32'(m_mask);
            2'd2:    exp_rd = 32'(m_edge);
            default: exp_rd = 32'(m_count);
        endcase
        for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
        new_level = m_level;
        for (int k = 0; k < NK; k++) begin
            all_diff = 1'b1;
            for (int j = 2; j < DB + 2; j++)
                if (hist[j][k] == m_level[k]) all_diff = 1'b0;
            if (all_diff) new_level[k] = ~m_level[k];
        end
        press = m_level & ~new_level;
        p     = popc(press);
        clr   = (write && address == 2'd2) ? writedata[NK-1:0] : '0;
        m_edge = (m_edge & ~clr) | press;
        if (write && address == 2'd1) m_mask = writedata[NK-1:0];
        if (write && address == 2'd3) m_count = p;
        else                          m_count = (m_count + p > 65535) ? 65535 : m_count + p;
        m_level = new_level;
        exp_irq = |(m_edge & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("readdata", readdata, exp_rd);
        check("irq", {31'b0, irq}, {31'b0, exp_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        tick();
        v = readdata;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        ticks(cycles);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v, c0;
        reset_n   = 1'b0;
        in_port   = '1;
        address   = 2'd0;
        write     = 1'b0;
        writedata = '0;
        model_reset();
        @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(3);
        rd(2'd0, v); check("idle_level", v, 32'h3);

        // Key0 pressed and held
        in_port = 2'b10;
        ticks(7);
        check("press_level", readdata, 32'h2);
        rd(2'd2, v); check("press_edge", v, 32'h1);
        rd(2'd3, v); check("press_count", v, 32'h1);
        in_port = 2'b11;
        ticks(8);
        wr(2'd2, 32'h3);
        wr(2'd3, 32'h0);

        // Key1 glitch shorter than the debounce window
        in_port = 2'b01;
        ticks(3);
        in_port = 2'b11;
        ticks(8);
        rd(2'd0, v); check("glitch_level", v, 32'h3);
        rd(2'd2, v); check("glitch_edge", v, 32'h0);
        check("glitch_irq", {31'b0, irq}, 32'h0);
        rd(2'd3, v); check("glitch_count", v, 32'h0);

        wr(2'd0, 32'h0);
        rd(2'd0, v); check("addr0_ro", v, 32'h3);

        // Masked interrupt, clear, re-press
        wr(2'd1, 32'h1);
        rd(2'd1, v); check("mask_rd", v, 32'h1);
        in_port = 2'b10;
        ticks(6);
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h1);
        check("irq_clr", {31'b0, irq}, 32'h0);
        in_port = 2'b11;
        ticks(8);
        in_port = 2'b10;
        ticks(6);
        check("irq_repress", {31'b0, irq}, 32'h1);
        rd(2'd2, v); check("edge_repress", v, 32'h1);
        in_port = 2'b11;
        ticks(8);
        wr(2'd2, 32'h3);
        wr(2'd1, 32'h0);

        // W1C in the same cycle as a key1 press event
        rd(2'd3, c0);
        in_port = 2'b01;
        ticks(5);
        wr(2'd2, 32'h2);
        rd(2'd2, v); check("w1c_event_wins", v, 32'h2);
        rd(2'd3, v); check("w1c_count", v, c0 + 32'd1);
        in_port = 2'b11;
        ticks(8);
        wr(2'd2, 32'h3);

        // Simultaneous presses, then saturation
        rd(2'd3, c0);
        in_port = 2'b00;
        ticks(6);
        rd(2'd2, v); check("both_edge", v, 32'h3);
        rd(2'd3, v); check("both_count", v, c0 + 32'd2);
        in_port = 2'b11;
        ticks(8);
        wr(2'd2, 32'h3);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        m_count = 65535;
        rd(2'd3, v); check("sat_preload", v, 32'hFFFF);
        in_port = 2'b00;
        ticks(6);
        rd(2'd3, v); check("sat_hold", v, 32'hFFFF);
        in_port = 2'b11;
        ticks(8);
        wr(2'd3, 32'h5);
        rd(2'd3, v); check("count_clear", v, 32'h0);

        // Reset mid-debounce with key0 held through it
        wr(2'd1, 32'h3);
        in_port = 2'b10;
        ticks(4);
        do_reset(1);
        rd(2'd1, v); check("rst_mask", v, 32'h0);
        address = 2'd2;
        ticks(5);
        check("rst_no_early_event", readdata, 32'h0);
        tick();
        check("rst_event_after", readdata, 32'h1);
        rd(2'd0, v); check("rst_level", v, 32'h2);
        rd(2'd3, v); check("rst_count", v, 32'h1);

        // Random traffic
        for (int it = 0; it < 600; it++) begin
            if (it == 300) do_reset(2);
            if ($urandom_range(0, 5) == 0) in_port = NK'($urandom);
            address = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                write     = 1'b1;
                writedata = $urandom;
            end else begin
                write     = 1'b0;
                writedata = '0;
            end
            tick();
        end
        write = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
